// File: rtl/kf8237_address_output_stage.sv
// Upper-address path of the 8237 DMA controller as used on the PC-XT bus.
// Drives AEN and ADSTB, models the 8282 upper-address latch, and holds the 74LS670-style page registers.
module kf8237_address_output_stage #(
   parameter int PAGE_WIDTH = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      hold_acknowledge,
   input  logic                      transfer_start,
   input  logic [1:0]                dma_select,
   input  logic [15:0]               transfer_address,
   input  logic                      next_word,
   input  logic                      update_high_address,
   input  logic                      end_of_process,
   input  logic                      write_page,
   input  logic [1:0]                page_select,
   input  logic [PAGE_WIDTH-1:0]     page_data,
   output logic                      address_enable,
   output logic                      address_strobe,
   output logic [7:0]                data_bus_out,
   output logic                      data_bus_out_enable,
   output logic [16+PAGE_WIDTH-1:0]  address_out,
   output logic                      busy
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      LATCHED,
      REFRESH
   } stateT;

   stateT                  state_q, state_d;
   logic [PAGE_WIDTH-1:0]  pageReg_q [4];
   logic [PAGE_WIDTH-1:0]  activePage_q, activePage_d;
   logic [7:0]             latch_q, latch_d;
   logic                   terminate;

   assign terminate = end_of_process || !hold_acknowledge;

   // Termination beats every other transition; the latch only loads on a strobe that completes.
   always_comb begin
      state_d      = state_q;
      latch_d      = latch_q;
      activePage_d = activePage_q;
      case (state_q)
         IDLE: begin
            if (transfer_start && hold_acknowledge) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (terminate) begin
               state_d = IDLE;
            end else begin
               activePage_d = pageReg_q[dma_select];
               state_d      = STROBE;
            end
         end
         STROBE: begin
            if (terminate) begin
               state_d = IDLE;
            end else begin
               latch_d = transfer_address[15:8];
               state_d = LATCHED;
            end
         end
         LATCHED: begin
            if (terminate) begin
               state_d = IDLE;
            end else if (next_word && update_high_address) begin
               state_d = REFRESH;
            end
         end
         REFRESH: begin
            if (terminate) begin
               state_d = IDLE;
            end else begin
               state_d = STROBE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Falling-edge flops keep this stage in step with the address/count register file.
   always_ff @(negedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         latch_q      <= 8'h00;
         activePage_q <= '0;
         for (int i = 0; i < 4; i++) begin
            pageReg_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         latch_q      <= latch_d;
         activePage_q <= activePage_d;
         if (write_page) begin
            pageReg_q[page_select] <= page_data;
         end
      end
   end

   assign address_enable      = (state_q != IDLE);
   assign busy                = (state_q != IDLE);
   assign address_strobe      = (state_q == STROBE);
   assign data_bus_out_enable = (state_q == STROBE);
   assign data_bus_out        = (state_q == STROBE) ? transfer_address[15:8] : 8'h00;
   assign address_out         = address_enable ? {activePage_q, latch_q, transfer_address[7:0]} : '0;

endmodule

// File: tb/tb_kf8237_address_output_stage.sv
// Bench for the DMA upper-address stage: directed scenarios followed by random traffic,
// all scored against a cycle-timeline reference model.
module tb_kf8237_address_output_stage;

   logic        clock;
   logic        reset;
   logic        hold_acknowledge;
   logic        transfer_start;
   logic [1:0]  dma_select;
   logic [15:0] transfer_address;
   logic        next_word;
   logic        update_high_address;
   logic        end_of_process;
   logic        write_page;
   logic [1:0]  page_select;
   logic [3:0]  page_data;
   logic        address_enable;
   logic        address_strobe;
   logic [7:0]  data_bus_out;
   logic        data_bus_out_enable;
   logic [19:0] address_out;
   logic        busy;

   int tests    = 0;
   int failures = 0;

   logic [3:0] modelPage [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
   logic [7:0] modelLatch    = 8'h00;
   logic [3:0] modelActPage  = 4'h0;
   logic       modelActive   = 1'b0;
   int         cyc           = 0;
   int         capCycle      = -10;
   int         strobeCycle   = -10;

   kf8237_address_output_stage #(.PAGE_WIDTH(4)) dut (
      .clock               (clock),
      .reset               (reset),
      .hold_acknowledge    (hold_acknowledge),
      .transfer_start      (transfer_start),
      .dma_select          (dma_select),
      .transfer_address    (transfer_address),
      .next_word           (next_word),
      .update_high_address (update_high_address),
      .end_of_process      (end_of_process),
      .write_page          (write_page),
      .page_select         (page_select),
      .page_data           (page_data),
      .address_enable      (address_enable),
      .address_strobe      (address_strobe),
      .data_bus_out        (data_bus_out),
      .data_bus_out_enable (data_bus_out_enable),
      .address_out         (address_out),
      .busy                (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Service is a timeline: a start schedules the page capture one edge later and the strobe two edges later;
   // an accepted high-address update schedules another strobe two edges out.
   task automatic applyStimulus();
      logic strobing;
      #1;
      strobing = modelActive && (strobeCycle == cyc);
      checkOutput("aen",   address_enable,      modelActive);
      checkOutput("busy",  busy,                modelActive);
      checkOutput("adstb", address_strobe,      strobing);
      checkOutput("dbe",   data_bus_out_enable, strobing);
      checkOutput("dbus",  data_bus_out,        strobing ? transfer_address[15:8] : 8'h00);
      checkOutput("addr",  address_out,
                  modelActive ? {modelActPage, modelLatch, transfer_address[7:0]} : 20'h0);
      @(negedge clock);
      if (reset) begin
         modelActive  = 1'b0;
         modelLatch   = 8'h00;
         modelActPage = 4'h0;
         for (int i = 0; i < 4; i++) modelPage[i] = 4'h0;
      end else begin
         if (modelActive) begin
            if (end_of_process || !hold_acknowledge) begin
               modelActive = 1'b0;
            end else begin
               if (cyc == capCycle) modelActPage = modelPage[dma_select];
               if (cyc == strobeCycle) modelLatch = transfer_address[15:8];
               else if (strobeCycle < cyc && next_word && update_high_address) strobeCycle = cyc + 2;
            end
         end else if (transfer_start && hold_acknowledge) begin
            modelActive = 1'b1;
            capCycle    = cyc + 1;
            strobeCycle = cyc + 2;
         end
         if (write_page) modelPage[page_select] = page_data;
      end
      cyc++;
      @(posedge clock);
   endtask

   initial begin
      reset = 1'b1;
      hold_acknowledge = 1'b0;
      transfer_start = 1'b0;
      dma_select = 2'd0;
      transfer_address = 16'h0;
      next_word = 1'b0;
      update_high_address = 1'b0;
      end_of_process = 1'b0;
      write_page = 1'b0;
      page_select = 2'd0;
      page_data = 4'h0;
      @(negedge clock);
      @(posedge clock);
      reset = 1'b0;
      #1;
      checkOutput("resetAen", address_enable, 0);
      checkOutput("resetAddr", address_out, 0);
      applyStimulus();

      // Page load and first service of channel 2
      write_page = 1'b1; page_select = 2'd2; page_data = 4'hA;
      applyStimulus();
      write_page = 1'b0;
      hold_acknowledge = 1'b1; transfer_start = 1'b1; dma_select = 2'd2; transfer_address = 16'h1234;
      applyStimulus();
      transfer_start = 1'b0;
      #1;
      checkOutput("setupAen", address_enable, 1);
      checkOutput("setupAdstb", address_strobe, 0);
      applyStimulus();
      #1;
      checkOutput("strobeAdstb", address_strobe, 1);
      checkOutput("strobeDbus", data_bus_out, 8'h12);
      checkOutput("strobeDbe", data_bus_out_enable, 1);
      applyStimulus();
      #1;
      checkOutput("latchedAddr", address_out, 20'hA1234);
      checkOutput("latchedAdstb", address_strobe, 0);
      checkOutput("latchedBusy", busy, 1);
      applyStimulus();

      // Word without carry, then a carry into A8
      transfer_address = 16'h12FF; next_word = 1'b1;
      applyStimulus();
      next_word = 1'b0;
      applyStimulus();
      next_word = 1'b1; update_high_address = 1'b1;
      applyStimulus();
      next_word = 1'b0; update_high_address = 1'b0; transfer_address = 16'h1300;
      #1;
      checkOutput("refreshAdstb", address_strobe, 0);
      applyStimulus();
      #1;
      checkOutput("carryDbus", data_bus_out, 8'h13);
      applyStimulus();
      #1;
      checkOutput("carryAddr", address_out, 20'hA1300);
      applyStimulus();

      // Page write and start pulse while busy
      write_page = 1'b1; page_select = 2'd2; page_data = 4'h3;
      applyStimulus();
      write_page = 1'b0; transfer_start = 1'b1;
      applyStimulus();
      transfer_start = 1'b0;
      #1;
      checkOutput("midPage", address_out[19:16], 4'hA);
      checkOutput("midBusyAdstb", address_strobe, 0);
      applyStimulus();

      // Terminate in LATCHED
      end_of_process = 1'b1;
      applyStimulus();
      end_of_process = 1'b0;
      #1;
      checkOutput("eopBusy", busy, 0);
      checkOutput("eopAddr", address_out, 0);
      applyStimulus();

      // Terminate in STROBE: latch must keep 0x13
      transfer_start = 1'b1; transfer_address = 16'h5678;
      applyStimulus();
      transfer_start = 1'b0;
      applyStimulus();
      end_of_process = 1'b1;
      applyStimulus();
      end_of_process = 1'b0;
      transfer_start = 1'b1; transfer_address = 16'h9999;
      applyStimulus();
      transfer_start = 1'b0;
      #1;
      checkOutput("retainAddr", address_out, 20'h31399);
      applyStimulus();
      applyStimulus();
      #1;
      checkOutput("restartAddr", address_out, 20'h39999);
      applyStimulus();

      // Hold loss in REFRESH
      next_word = 1'b1; update_high_address = 1'b1;
      applyStimulus();
      next_word = 1'b0; update_high_address = 1'b0; hold_acknowledge = 1'b0;
      applyStimulus();
      hold_acknowledge = 1'b1;
      #1;
      checkOutput("holdLossBusy", busy, 0);
      applyStimulus();

      // Reset during STROBE clears pages
      transfer_start = 1'b1;
      applyStimulus();
      transfer_start = 1'b0;
      applyStimulus();
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
      #1;
      checkOutput("rstMidAen", address_enable, 0);
      checkOutput("rstMidAdstb", address_strobe, 0);
      transfer_start = 1'b1;
      applyStimulus();
      transfer_start = 1'b0;
      applyStimulus();
      applyStimulus();
      #1;
      checkOutput("rstPage", address_out[19:16], 4'h0);
      applyStimulus();

      // Start without grant
      end_of_process = 1'b1;
      applyStimulus();
      end_of_process = 1'b0; hold_acknowledge = 1'b0; transfer_start = 1'b1;
      applyStimulus();
      transfer_start = 1'b0;
      #1;
      checkOutput("noGrantBusy", busy, 0);
      checkOutput("noGrantAddr", address_out, 0);
      applyStimulus();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         reset               = ($urandom_range(99) < 2);
         hold_acknowledge    = ($urandom_range(99) < 94);
         end_of_process      = ($urandom_range(99) < 4);
         transfer_start      = ($urandom_range(99) < 20);
         dma_select          = 2'($urandom_range(3));
         transfer_address    = 16'($urandom);
         next_word           = ($urandom_range(99) < 40);
         update_high_address = ($urandom_range(99) < 50);
         write_page          = ($urandom_range(99) < 15);
         page_select         = 2'($urandom_range(3));
         page_data           = 4'($urandom_range(15));
         applyStimulus();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
